// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU operand sequencer.
//   - state_e      : sequencer states S_A, S_B, S_OP, S_RUN, S_SHOW
//   - OP_*         : ALU opcodes 0..7
//   - SEG_*        : 7-segment patterns for "0", "1" and blank
//   - seg_of()     : bit value to digit pattern
//   - alu_golden() : reference ALU, built only with ALU_SEQ_SELF_CHECK_EN
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_RUN  = 3'd3,
    S_SHOW = 3'd4
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_GT  = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;

  localparam logic [6:0] SEG_ZERO  = 7'd64;
  localparam logic [6:0] SEG_ONE   = 7'd121;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_of(input logic v);
    return v ? SEG_ONE : SEG_ZERO;
  endfunction

`ifdef ALU_SEQ_SELF_CHECK_EN
  // Returns {result, cf, of}. Subtraction reports borrow, so its carry is
  // the inverted carry-out of a + ~b + 1.
  function automatic logic [5:0] alu_golden(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [2:0] sel);
    logic [4:0] s;
    logic [3:0] r;
    logic       cf;
    logic       of;
    s  = 5'd0;
    r  = 4'd0;
    cf = 1'b0;
    of = 1'b0;
    case (sel)
      OP_ADD: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[3:0];
        cf = s[4];
        of = (a[3] == b[3]) && (r[3] != a[3]);
      end
      OP_SUB: begin
        s  = {1'b0, a} + {1'b0, ~b} + 5'd1;
        r  = s[3:0];
        cf = ~s[4];
        of = (a[3] != b[3]) && (r[3] != a[3]);
      end
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_GT:   r = {3'b000, ($signed(a) > $signed(b))};
      default: r = {3'b000, (a == b)};
    endcase
    return {r, cf, of};
  endfunction
`endif

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises a raw active-low key and debounces it.
//   clk, rst_n : clock, asynchronous active-low reset
//   key_n      : raw key level, asynchronous to clk, low = pressed
//   press      : one-cycle strobe on each accepted press (1->0 of the
//                debounced level); release produces nothing
module key_debounce #(
  parameter int DEB_CNT = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT + 1) : 1;

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // The counter runs only while the synchronised level disagrees with the
  // debounced level; any return to agreement restarts it from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CNT - 1)) begin
        deb_q   <= sync2_q;
        cnt_q   <= '0;
        press_q <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: steps operands/opcode from switches into a
// combinational ALU, waits a settle time, captures and displays the result.
//   clk, rst_n               : clock, asynchronous active-low reset
//   sw[3:0]                  : operand / opcode entry switches
//   key_next_n, key_back_n   : raw active-low keys
//   alu_result, alu_cf/of    : ALU outputs
//   a, b, sel                : ALU inputs, held until re-latched
//   res_q, cf_q, of_q        : captured ALU outputs
//   done                     : high while a captured result is shown
//   stage_led[4:0]           : one-hot current state, bit 0 = S_A
//   hex_res0..3, hex_cf/of   : registered per-bit digits
//   mismatch                 : self-check flag
// Optional build macro ALU_SEQ_SELF_CHECK_EN adds a golden ALU model that
// sets mismatch at capture; otherwise mismatch is tied low.
// Key strobes are single-cycle events with no backpressure: each accepted
// strobe acts at most once, and strobes from both keys in one cycle cancel.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEB_CNT       = 500000,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       key_next_n,
  input  logic       key_back_n,
  input  logic [3:0] alu_result,
  input  logic       alu_cf,
  input  logic       alu_of,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [2:0] sel,
  output logic [3:0] res_q,
  output logic       cf_q,
  output logic       of_q,
  output logic       done,
  output logic [4:0] stage_led,
  output logic [6:0] hex_res0,
  output logic [6:0] hex_res1,
  output logic [6:0] hex_res2,
  output logic [6:0] hex_res3,
  output logic [6:0] hex_cf,
  output logic [6:0] hex_of,
  output logic       mismatch
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic          next_p;
  logic          back_p;
  logic          nx;
  logic          bk;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    a_q;
  logic [3:0]    b_q;
  logic [2:0]    sel_q;
  logic [3:0]    cap_res_q;
  logic          cap_cf_q;
  logic          cap_of_q;
  logic          done_q;
  logic          cap_evt;
  logic [6:0]    hres_q [4];
  logic [6:0]    hcf_q;
  logic [6:0]    hof_q;

  key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_next (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_next_n),
    .press (next_p)
  );

  key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_back (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_back_n),
    .press (back_p)
  );

  assign nx      = next_p & ~back_p;
  assign bk      = back_p & ~next_p;
  assign cap_evt = (state_q == S_RUN) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_A;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= '0;
      cap_res_q <= '0;
      cap_cf_q  <= 1'b0;
      cap_of_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (nx) begin
            a_q     <= sw;
            state_q <= S_B;
          end
        end
        S_B: begin
          if (nx) begin
            b_q     <= sw;
            state_q <= S_OP;
          end else if (bk) begin
            state_q <= S_A;
          end
        end
        S_OP: begin
          if (nx) begin
            sel_q   <= sw[2:0];
            cnt_q   <= CW'(SETTLE_CYCLES - 1);
            state_q <= S_RUN;
          end else if (bk) begin
            state_q <= S_B;
          end
        end
        S_RUN: begin
          // Capture lands SETTLE_CYCLES edges after the sel update.
          if (cnt_q == '0) begin
            cap_res_q <= alu_result;
            cap_cf_q  <= alu_cf;
            cap_of_q  <= alu_of;
            done_q    <= 1'b1;
            state_q   <= S_SHOW;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_SHOW: begin
          if (nx) begin
            done_q  <= 1'b0;
            state_q <= S_A;
          end else if (bk) begin
            done_q  <= 1'b0;
            state_q <= S_OP;
          end
        end
        default: state_q <= S_A;
      endcase
    end
  end

  // Digits follow res_q/done one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hres_q[i] <= SEG_BLANK;
      hcf_q <= SEG_BLANK;
      hof_q <= SEG_BLANK;
    end else begin
      for (int i = 0; i < 4; i++) hres_q[i] <= done_q ? seg_of(cap_res_q[i]) : SEG_BLANK;
      hcf_q <= done_q ? seg_of(cap_cf_q) : SEG_BLANK;
      hof_q <= done_q ? seg_of(cap_of_q) : SEG_BLANK;
    end
  end

`ifdef ALU_SEQ_SELF_CHECK_EN
  logic mismatch_q;
  logic done_clr;

  assign done_clr = (state_q == S_SHOW) && (nx || bk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
    end else if (cap_evt) begin
      mismatch_q <= (alu_golden(a_q, b_q, sel_q) != {alu_result, alu_cf, alu_of});
    end else if (done_clr) begin
      mismatch_q <= 1'b0;
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

  assign a         = a_q;
  assign b         = b_q;
  assign sel       = sel_q;
  assign res_q     = cap_res_q;
  assign cf_q      = cap_cf_q;
  assign of_q      = cap_of_q;
  assign done      = done_q;
  assign stage_led = 5'd1 << state_q;
  assign hex_res0  = hres_q[0];
  assign hex_res1  = hres_q[1];
  assign hex_res2  = hres_q[2];
  assign hex_res3  = hres_q[3];
  assign hex_cf    = hcf_q;
  assign hex_of    = hof_q;

endmodule
